// File: rtl/video_tpg_ctrl.sv
// ---------------------------------------------------------------------------
// video_tpg_ctrl
//
// Run/stop controller and window animator for a video test-pattern
// generator. It watches a copy of the generator's AXI4-Stream output to keep
// its own line/frame position, enables the generator, and moves the
// horizontal/vertical window offsets along a triangle wave once per
// FRAME_DIV frames.
//
// Stream handshake: a beat is a cycle with mon_tvalid & mon_tready both
// high. Only beats are observed; tuser/tlast in any other cycle are ignored.
// mon_tuser marks the first beat of a frame (SOF), mon_tlast the last beat
// of a line.
//
// Ports
//   clk                      single clock
//   rst                      synchronous, active-high reset
//   start                    one-cycle pulse, request pattern generation
//   stop                     one-cycle pulse, stop at the next frame end
//   mon_tvalid/tready/tuser/tlast  monitored generator output stream
//   tpg_en                   generator enable
//   subh, addh, subw, addw   window offsets (13 bits each)
//   busy                     high in RUN or STOP_PEND
//   frame_cnt                completed frames since reset (wraps)
//   fsm_state                current FSM state (0 IDLE, 1 RUN, 2 STOP_PEND)
// ---------------------------------------------------------------------------
module video_tpg_ctrl #(
   parameter int SCRW      = 1920,
   parameter int SCRH      = 1080,
   parameter int STEP      = 4,
   parameter int FRAME_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        mon_tvalid,
   input  logic        mon_tready,
   input  logic        mon_tuser,
   input  logic        mon_tlast,
   output logic        tpg_en,
   output logic [12:0] subh,
   output logic [12:0] addh,
   output logic [12:0] subw,
   output logic [12:0] addw,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic [1:0]  fsm_state
);

   localparam logic [13:0] MAXW      = 14'(SCRW / 4);
   localparam logic [13:0] MAXH      = 14'(SCRH / 4);
   localparam logic [13:0] STEP_V    = 14'(STEP);
   localparam logic [11:0] LAST_LINE = 12'(SCRH - 1);
   localparam logic [7:0]  DIV_LAST  = 8'(FRAME_DIV - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      STOP_PEND = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        beat;
   logic        eof;
   logic        anim_upd;
   logic [11:0] line_cnt;
   logic [7:0]  div_cnt;
   logic [13:0] ofs_w;
   logic [13:0] ofs_h;
   logic        dir_w;     // 0 = up, 1 = down
   logic        dir_h;
   logic [14:0] nxt_w;     // {dir, offset}
   logic [14:0] nxt_h;

   // One triangle-wave step: climb by STEP until the limit, then descend to 0.
   function automatic logic [14:0] tri_next(input logic [13:0] ofs,
                                            input logic        down,
                                            input logic [13:0] lim);
      logic [14:0] res;
      if (!down) begin
         if (ofs + STEP_V >= lim) res = {1'b1, lim};
         else                     res = {1'b0, ofs + STEP_V};
      end else begin
         if (ofs <= STEP_V)       res = {1'b0, 14'd0};
         else                     res = {1'b1, ofs - STEP_V};
      end
      return res;
   endfunction

   assign beat = mon_tvalid & mon_tready;
   assign eof  = beat & mon_tlast & (line_cnt == LAST_LINE);

   // Updates only while the generator is enabled; the divider itself keeps
   // counting in every state so the cadence stays tied to the stream.
   assign anim_upd = eof & (div_cnt == DIV_LAST) & tpg_en;

   assign nxt_w = tri_next(ofs_w, dir_w, MAXW);
   assign nxt_h = tri_next(ofs_h, dir_h, MAXH);

   // ------------------------------------------------------------------
   // Stream position tracking (runs in every state)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         line_cnt  <= '0;
         div_cnt   <= '0;
         frame_cnt <= '0;
      end else if (beat) begin
         // SOF wins over tlast so a one-beat line still restarts at line 0.
         if (mon_tuser)      line_cnt <= '0;
         else if (eof)       line_cnt <= '0;
         else if (mon_tlast) line_cnt <= line_cnt + 12'd1;

         if (eof) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (div_cnt == DIV_LAST) div_cnt <= '0;
            else                     div_cnt <= div_cnt + 8'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Offset animation; offsets and directions persist across IDLE
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         ofs_w <= '0;
         ofs_h <= '0;
         dir_w <= 1'b0;
         dir_h <= 1'b0;
         subw  <= '0;
         addw  <= '0;
         subh  <= '0;
         addh  <= '0;
      end else if (anim_upd) begin
         dir_w <= nxt_w[14];
         ofs_w <= nxt_w[13:0];
         dir_h <= nxt_h[14];
         ofs_h <= nxt_h[13:0];
         subw  <= nxt_w[12:0];
         addw  <= nxt_w[12:0];
         subh  <= nxt_h[12:0];
         addh  <= nxt_h[12:0];
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start && !stop) state_nxt = RUN;
         end
         RUN: begin
            if (stop) state_nxt = STOP_PEND;
         end
         STOP_PEND: begin
            // Frame end beats a simultaneous restart request.
            if (eof)                 state_nxt = IDLE;
            else if (start && !stop) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (decoded from the state register only)
   // ------------------------------------------------------------------
   always_comb begin
      tpg_en    = 1'b0;
      busy      = 1'b0;
      fsm_state = state;
      if (state == RUN || state == STOP_PEND) begin
         tpg_en = 1'b1;
         busy   = 1'b1;
      end
   end

endmodule

// File: tb/tb_video_tpg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_video_tpg_ctrl
//
// Directed bench for video_tpg_ctrl with SCRW=16, SCRH=8, STEP=2,
// FRAME_DIV=1 (MAXW=4, MAXH=2). Inputs change 1 ns after a rising edge and
// outputs are read at the same point, i.e. they show the effect of that
// edge. Expected offset pairs {w,h} are hand-computed and queued in the
// order the animation updates should occur.
// ---------------------------------------------------------------------------
module tb_video_tpg_ctrl;

   localparam int SCRW = 16;
   localparam int SCRH = 8;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        mon_tvalid = 1'b0;
   logic        mon_tready = 1'b0;
   logic        mon_tuser = 1'b0;
   logic        mon_tlast = 1'b0;
   logic        tpg_en;
   logic [12:0] subh, addh, subw, addw;
   logic        busy;
   logic [15:0] frame_cnt;
   logic [1:0]  fsm_state;

   always #5 clk = ~clk;

   video_tpg_ctrl #(
      .SCRW(16), .SCRH(8), .STEP(2), .FRAME_DIV(1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
      .mon_tuser(mon_tuser), .mon_tlast(mon_tlast),
      .tpg_en(tpg_en), .subh(subh), .addh(addh), .subw(subw), .addw(addw),
      .busy(busy), .frame_cnt(frame_cnt), .fsm_state(fsm_state)
   );

   // ---------------- scoreboard ----------------
   logic [25:0] exp_q[$];
   logic [12:0] cur_w = '0;
   logic [12:0] cur_h = '0;
   logic [15:0] exp_fc = '0;
   int          total = 0;
   int          bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic check_offsets(input string tag);
      check({tag, "_subw"}, subw, cur_w);
      check({tag, "_addw"}, addw, cur_w);
      check({tag, "_subh"}, subh, cur_h);
      check({tag, "_addh"}, addh, cur_h);
   endtask

   task automatic next_offsets();
      logic [25:0] e;
      if (exp_q.size() == 0) begin
         check("queue_empty", 1, 0);
      end else begin
         e = exp_q.pop_front();
         cur_w = e[25:13];
         cur_h = e[12:0];
      end
   endtask

   // Sends nlines lines of SCRW beats starting with a SOF beat. Optional
   // valid-gap and ready-stall cycles (carrying junk tuser/tlast) mid-line, a
   // stop pulse before line stop_line, and a start pulse on the EOF beat.
   task automatic send_frame(input bit gaps, input int stop_line,
                             input bit start_eof, input bit exp_en,
                             input int nlines);
      for (int l = 0; l < nlines; l++) begin
         for (int p = 0; p < SCRW; p++) begin
            if (l == stop_line && p == 0) pulse_stop();
            if (gaps && p == 7) begin
               mon_tvalid = 1'b0; mon_tready = 1'b1;
               mon_tuser = 1'b1; mon_tlast = 1'b1;
               tick();
               mon_tvalid = 1'b1; mon_tready = 1'b0;
               tick();
               mon_tvalid = 1'b0; mon_tready = 1'b0;
               mon_tuser = 1'b0; mon_tlast = 1'b0;
            end
            mon_tvalid = 1'b1;
            mon_tready = 1'b1;
            mon_tuser  = (l == 0 && p == 0);
            mon_tlast  = (p == SCRW - 1);
            if (start_eof && l == SCRH - 1 && p == SCRW - 1) start = 1'b1;
            tick();
            mon_tvalid = 1'b0; mon_tready = 1'b0;
            mon_tuser = 1'b0; mon_tlast = 1'b0;
            start = 1'b0;
         end
         if (l < SCRH - 1) begin
            check("line_fcnt", frame_cnt, exp_fc);
            check("line_en", tpg_en, exp_en);
            check("line_subw", subw, cur_w);
            check("line_subh", subh, cur_h);
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // expected {w,h} after each animation update
      exp_q.push_back({13'd2, 13'd2});
      exp_q.push_back({13'd4, 13'd0});
      exp_q.push_back({13'd2, 13'd2});
      exp_q.push_back({13'd0, 13'd0});
      exp_q.push_back({13'd2, 13'd2});
      exp_q.push_back({13'd4, 13'd0});
      exp_q.push_back({13'd2, 13'd2});
      exp_q.push_back({13'd0, 13'd0});
      exp_q.push_back({13'd2, 13'd2});  // stop frame
      exp_q.push_back({13'd4, 13'd0});  // resume
      exp_q.push_back({13'd2, 13'd2});  // cancelled stop
      exp_q.push_back({13'd0, 13'd0});  // stop + start on EOF
      exp_q.push_back({13'd2, 13'd2});  // after mid-frame reset

      // reset
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check("rst_en", tpg_en, 0);
      check("rst_busy", busy, 0);
      check("rst_fcnt", frame_cnt, 0);
      check("rst_state", fsm_state, 0);
      check_offsets("rst");

      // start
      pulse_start();
      check("start_en", tpg_en, 1);
      check("start_busy", busy, 1);
      check_offsets("start");

      // four clean frames, then four with gaps and stalls
      for (int g = 0; g < 2; g++) begin
         for (int f = 0; f < 4; f++) begin
            send_frame(g[0], -1, 1'b0, 1'b1, SCRH);
            exp_fc++;
            next_offsets();
            check("frame_fcnt", frame_cnt, exp_fc);
            check_offsets("frame");
         end
      end
      check("fcnt8", frame_cnt, 8);

      // stop at line 3: enable holds to EOF, drops the cycle after
      send_frame(1'b0, 3, 1'b0, 1'b1, SCRH);
      exp_fc++;
      next_offsets();
      check("stop_en", tpg_en, 0);
      check("stop_busy", busy, 0);
      check("stop_state", fsm_state, 0);
      check_offsets("stop");

      // idle frame: tracking continues, offsets hold
      send_frame(1'b0, -1, 1'b0, 1'b0, SCRH);
      exp_fc++;
      check("idle_fcnt", frame_cnt, exp_fc);
      check("idle_en", tpg_en, 0);
      check_offsets("idle");

      // restart resumes from held offsets
      pulse_start();
      check("resume_en", tpg_en, 1);
      send_frame(1'b0, -1, 1'b0, 1'b1, SCRH);
      exp_fc++;
      next_offsets();
      check("resume_fcnt", frame_cnt, exp_fc);
      check_offsets("resume");

      // stop then start before EOF cancels the stop
      pulse_stop();
      check("pend_state", fsm_state, 2);
      check("pend_en", tpg_en, 1);
      pulse_start();
      check("cancel_state", fsm_state, 1);
      check("cancel_en", tpg_en, 1);
      send_frame(1'b0, -1, 1'b0, 1'b1, SCRH);
      exp_fc++;
      next_offsets();
      check("cancel_after_en", tpg_en, 1);
      check_offsets("cancel");

      // stop, then start on the EOF beat itself: EOF wins
      send_frame(1'b0, 2, 1'b1, 1'b1, SCRH);
      exp_fc++;
      next_offsets();
      check("eofstart_state", fsm_state, 0);
      check("eofstart_en", tpg_en, 0);
      check("eofstart_fcnt", frame_cnt, exp_fc);
      check_offsets("eofstart");

      // start & stop together in IDLE: stay idle
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check("both_state", fsm_state, 0);
      check("both_en", tpg_en, 0);
      check("both_busy", busy, 0);

      // reset in line 5 while running
      pulse_start();
      send_frame(1'b0, -1, 1'b0, 1'b1, 5);
      for (int p = 0; p < 3; p++) begin
         mon_tvalid = 1'b1; mon_tready = 1'b1;
         tick();
         mon_tvalid = 1'b0; mon_tready = 1'b0;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cur_w = '0; cur_h = '0; exp_fc = '0;
      check("mrst_en", tpg_en, 0);
      check("mrst_busy", busy, 0);
      check("mrst_fcnt", frame_cnt, 0);
      check("mrst_state", fsm_state, 0);
      check_offsets("mrst");

      // EOF exactly on the 8th tlast after SOF
      pulse_start();
      check("mrst_start_en", tpg_en, 1);
      send_frame(1'b0, -1, 1'b0, 1'b1, SCRH);
      exp_fc++;
      next_offsets();
      check("mrst_eof_fcnt", frame_cnt, exp_fc);
      check_offsets("mrst_eof");
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/video_tpg_ctrl.md
VIDEO_TPG_CTRL -- requirements
Module: video_tpg_ctrl

Interface
- REQ-001: SCRW, default 1920, active pixels per line.
- REQ-002: SCRH, default 1080, active lines per frame.
- REQ-003: STEP, default 4, offset increment per animation update.
- REQ-004: FRAME_DIV, default 1, end-of-frame (EOF) events per animation update (range 1..255).
- REQ-005: clk  in  1  single clock for all logic.
- REQ-006: rst  in  1  reset, synchronous, active-high.
- REQ-007: start  in  1  one-cycle pulse; requests pattern generation.
- REQ-008: stop  in  1  one-cycle pulse; requests stop at the next frame boundary.
- REQ-009: mon_tvalid, mon_tready, mon_tuser, mon_tlast  in  1 each  monitored copy of the pattern generator AXI4-Stream output.
- REQ-010: tpg_en  out  1  enable to the pattern generator.
- REQ-011: subh, addh, subw, addw  out  13 each  window offsets to the pattern generator.
- REQ-012: busy  out  1  high in RUN or STOP_PEND.
- REQ-013: frame_cnt  out  16  count of completed frames since reset.

Function
- REQ-014: The block SHALL define a beat as mon_tvalid & mon_tready in the same cycle; non-beat cycles SHALL be ignored.
- REQ-015: The block SHALL use a three-state FSM: IDLE, RUN, STOP_PEND.
- REQ-016: IDLE: tpg_en=0 and busy=0; start & !stop -> RUN; start & stop -> stay in IDLE (stop wins).
- REQ-017: RUN: tpg_en=1 and busy=1 from the cycle after the transition; stop -> STOP_PEND; start SHALL be ignored.
- REQ-018: STOP_PEND: tpg_en=1; on an EOF beat -> IDLE, with tpg_en=0 from the next cycle; start & !stop without EOF -> RUN (cancel); EOF and start in the same cycle -> IDLE.
- REQ-019: A 12-bit line counter SHALL be set to 0 on a beat with mon_tuser=1 (SOF), including when that beat also has mon_tlast=1.
- REQ-020: The line counter SHALL increment on each beat with mon_tlast=1.
- REQ-021: A beat with mon_tlast=1 while the line counter is SCRH-1 SHALL be an EOF beat, and the line counter SHALL wrap to 0.
- REQ-022: Beat, line and EOF tracking SHALL run in every state, so the counters stay synchronized while idle.
- REQ-023: frame_cnt SHALL increment by 1 on every EOF beat and wrap from 0xFFFF to 0.
- REQ-024: An 8-bit divider SHALL count EOF beats; the animation SHALL update, and the divider clear, when the divider reaches FRAME_DIV-1 on an EOF beat.
- REQ-025: Animation updates SHALL occur only while tpg_en=1.
- REQ-026: Horizontal offset ofs_w SHALL follow a triangle wave between 0 and MAXW=SCRW/4, using 14-bit arithmetic, with a direction flag dir_w.
- REQ-027: ofs_w, dir_w up: if ofs_w+STEP >= MAXW then ofs_w=MAXW and dir_w=down, else ofs_w+=STEP.
- REQ-028: ofs_w, dir_w down: if ofs_w <= STEP then ofs_w=0 and dir_w=up, else ofs_w-=STEP.
- REQ-029: Vertical offset ofs_h SHALL follow the same triangle rules with MAXH=SCRH/4 and its own flag dir_h.
- REQ-030: Outputs SHALL be registered as subw=addw=ofs_w[12:0] and subh=addh=ofs_h[12:0].
- REQ-031: The new offset values SHALL appear in the cycle after the EOF beat and hold constant for the whole following frame.
- REQ-032: Latency SHALL be one cycle from start, stop or an EOF beat to the resulting output change; there SHALL be no combinational path from inputs to outputs.
- REQ-033: Offsets and direction flags SHALL be retained across IDLE, so a restart resumes the animation.

Reset
- REQ-034: While rst=1 at a clk edge: state=IDLE, tpg_en=0, busy=0, all offsets=0, dir_w=dir_h=up, line counter=0, divider=0, frame_cnt=0.
- REQ-035: A reset asserted mid-frame in any state SHALL take priority over all other inputs; after reset, tracking SHALL resynchronize at the next SOF beat.

Verification (SCRW=16, SCRH=8, STEP=2, FRAME_DIV=1, so MAXW=4 and MAXH=2)
- REQ-036: Reset, then pulse start -> tpg_en=1 and busy=1 one cycle later; all offsets=0.
- REQ-037: Run frames of 8 lines × 16 beats -> after EOF1: subw=addw=2, subh=addh=2; EOF2: w=4, h=0; EOF3: w=2, h=2; EOF4: w=0, h=0; frame_cnt=4.
- REQ-038: Insert mon_tvalid=0 gaps and mon_tready=0 stalls mid-line -> offsets change only in the cycle after each EOF beat; values match the previous scenario.
- REQ-039: stop at line 3 of a frame -> tpg_en stays 1 until the EOF beat, 0 the cycle after; busy=0; a later start resumes from the held offsets.
- REQ-040: In STOP_PEND, pulse start before EOF -> state returns to RUN and tpg_en never drops; start and stop together in IDLE -> remains IDLE.
- REQ-041: Assert rst at line 5 while running -> all outputs 0 the next cycle; after start and a SOF beat, EOF is detected after exactly 8 tlast beats.
